dift_tag_check_unit: RTL and testbench

//  Parametrised DIFT tag check unit for CV32E40P ID stage; checks exec, JALR, branch, store and load tag policies per TCCR.
//  A per-bit tag mask selects which tag bits are checked. Violations raise a held trap request (req/ack to the controller).

---
 rtl/dift_tag_check_unit.sv | 132 +++++++++++++
 tb/tb_dift_tag_check_unit.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/dift_tag_check_unit.sv
// dift_tag_check_unit: DIFT tag policy checker with held trap request and saturating violation counter
package dift_pkg;
  localparam logic [1:0] BRANCH_NONE = 2'b00;
  localparam logic [1:0] BRANCH_JAL  = 2'b01;
  localparam logic [1:0] BRANCH_JALR = 2'b10;
  localparam logic [1:0] BRANCH_COND = 2'b11;
  typedef enum logic [1:0] {DIFT_OPCLASS_OTHER, DIFT_OPCLASS_LOAD, DIFT_OPCLASS_STORE, DIFT_OPCLASS_ALU} dift_opclass_t;
  typedef enum logic [1:0] {DIFT_BR_OFF, DIFT_BR_OR, DIFT_BR_AND, DIFT_BR_SINGL} dift_br_mode_t;
  typedef enum logic {DIFT_SEL_OP_A, DIFT_SEL_OP_B} dift_sel_t;
  typedef struct packed {
    dift_br_mode_t mode;
    dift_sel_t     single_mode_select;
  } dift_br_cfg_t;
  typedef struct packed {
    logic         exec;
    logic         jalr;
    dift_br_cfg_t branch;
    logic         store;
    logic         load;
  } dift_tccr_t;
  typedef enum logic [2:0] {
    DIFT_TRAP_TYPE_NONE, DIFT_TRAP_TYPE_EXEC, DIFT_TRAP_TYPE_JALR,
    DIFT_TRAP_TYPE_BRAN, DIFT_TRAP_TYPE_STOR, DIFT_TRAP_TYPE_LOAD
  } dift_trap_t;
endpackage

module dift_tag_check_unit
  import dift_pkg::*;
#(
  parameter int TAG_W   = 4,
  parameter int CNT_W   = 16,
  parameter int HOLDOFF = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  input  logic [TAG_W-1:0] instr_tag_i,
  input  logic [1:0]       jump_in_i,
  input  logic [TAG_W-1:0] jump_target_tag_i,
  input  logic [TAG_W-1:0] operand_a_tag_i,
  input  logic [TAG_W-1:0] operand_b_tag_i,
  input  dift_opclass_t    opclass_i,
  input  dift_tccr_t       tccr_i,
  input  logic [TAG_W-1:0] tag_mask_i,
  input  logic [31:0]      pc_i,
  input  logic             trap_ack_i,
  input  logic             viol_cnt_clr_i,
  output logic             trap_req_o,
  output dift_trap_t       trap_type_o,
  output logic [31:0]      trap_pc_o,
  output logic [CNT_W-1:0] viol_cnt_o,
  output logic             viol_ovf_o
);
  localparam int HW = HOLDOFF > 0 ? $clog2(HOLDOFF + 1) : 1;
  typedef enum logic [1:0] {IDLE, PEND, HOLD} state_t;
  state_t           state_q;
  dift_trap_t       type_q;
  logic [31:0]      pc_q;
  logic [HW-1:0]    hold_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             t_instr, t_tgt, t_a, t_b, br_hit;
  logic             d_exec, d_jalr, d_bran, d_stor, d_load, det;
  dift_trap_t       det_type;
  assign t_instr = |(instr_tag_i & tag_mask_i);
  assign t_tgt   = |(jump_target_tag_i & tag_mask_i);
  assign t_a     = |(operand_a_tag_i & tag_mask_i);
  assign t_b     = |(operand_b_tag_i & tag_mask_i);
  // branch policy: which operand taint combination counts as a violation
  always_comb
    br_hit = tccr_i.branch.mode == DIFT_BR_OR  ? (t_a | t_b) :
             tccr_i.branch.mode == DIFT_BR_AND ? (t_a & t_b) :
             tccr_i.branch.mode == DIFT_BR_SINGL ?
               (tccr_i.branch.single_mode_select == DIFT_SEL_OP_B ? t_b : t_a) : 1'b0;
  assign d_exec = valid_i & tccr_i.exec & t_instr;
  assign d_jalr = valid_i & (jump_in_i == BRANCH_JALR) & tccr_i.jalr & t_tgt;
  assign d_bran = valid_i & (jump_in_i == BRANCH_COND) & br_hit;
  assign d_stor = valid_i & (opclass_i == DIFT_OPCLASS_STORE) & tccr_i.store & t_a;
  assign d_load = valid_i & (opclass_i == DIFT_OPCLASS_LOAD) & tccr_i.load & t_a;
  assign det    = d_exec | d_jalr | d_bran | d_stor | d_load;
  // highest-priority violating check names the trap
  always_comb
    det_type = d_exec ? DIFT_TRAP_TYPE_EXEC :
               d_jalr ? DIFT_TRAP_TYPE_JALR :
               d_bran ? DIFT_TRAP_TYPE_BRAN :
               d_stor ? DIFT_TRAP_TYPE_STOR :
               d_load ? DIFT_TRAP_TYPE_LOAD : DIFT_TRAP_TYPE_NONE;
  // trap FSM: only a detection in IDLE opens a trap; later ones are counted elsewhere
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      type_q  <= DIFT_TRAP_TYPE_NONE;
      pc_q    <= '0;
      hold_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (det) begin
          state_q <= PEND;
          type_q  <= det_type;
          pc_q    <= pc_i;
        end
        PEND: if (trap_ack_i) begin
          state_q <= HOLDOFF > 0 ? HOLD : IDLE;
          hold_q  <= HW'(HOLDOFF);
        end
        HOLD: begin
          hold_q  <= hold_q - HW'(1);
          state_q <= hold_q == HW'(1) ? IDLE : HOLD;
        end
        default: state_q <= IDLE;
      endcase
    end
  // saturating counter; clear wins over a same-cycle detection
  always_comb begin
    cnt_d = viol_cnt_clr_i ? '0 : (det && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
    ovf_d = !viol_cnt_clr_i & (ovf_q | (det & (&cnt_q)));
  end
  // counter state
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  assign trap_req_o  = state_q == PEND;
  assign trap_type_o = state_q == PEND ? type_q : DIFT_TRAP_TYPE_NONE;
  assign trap_pc_o   = state_q == PEND ? pc_q : '0;
  assign viol_cnt_o  = cnt_q;
  assign viol_ovf_o  = ovf_q;
endmodule

// File: tb/tb_dift_tag_check_unit.sv
// tb_dift_tag_check_unit: directed vector and sequence checks for the DIFT tag check unit
module tb_dift_tag_check_unit;
  import dift_pkg::*;
  logic clk = 0, rst_n = 0, valid = 0, ack = 0, clr = 0;
  logic [3:0] it = 0, tgt = 0, ta = 0, tb = 0, mask = 0;
  logic [1:0] jmp = BRANCH_NONE;
  dift_opclass_t opc = DIFT_OPCLASS_OTHER;
  dift_tccr_t tccr = '0;
  logic [31:0] pc = 0;
  logic req, ovf;
  dift_trap_t ttype;
  logic [31:0] tpc;
  logic [1:0] cnt;
  int tests = 0, fails = 0;

  dift_tag_check_unit #(.TAG_W(4), .CNT_W(2), .HOLDOFF(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid), .instr_tag_i(it), .jump_in_i(jmp),
    .jump_target_tag_i(tgt), .operand_a_tag_i(ta), .operand_b_tag_i(tb), .opclass_i(opc),
    .tccr_i(tccr), .tag_mask_i(mask), .pc_i(pc), .trap_ack_i(ack), .viol_cnt_clr_i(clr),
    .trap_req_o(req), .trap_type_o(ttype), .trap_pc_o(tpc), .viol_cnt_o(cnt), .viol_ovf_o(ovf));

  always #5 clk = ~clk;

  typedef struct {
    logic valid; logic [3:0] it, tgt, ta, tb, mask; logic [1:0] jmp;
    dift_opclass_t opc; dift_tccr_t tccr; logic exp_req; dift_trap_t exp_type;
  } vec_t;
  vec_t v[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic dift_tccr_t mk(input logic ex, jr, input dift_br_mode_t m, input dift_sel_t s, input logic st, ld);
    dift_tccr_t t;
    t.exec = ex; t.jalr = jr; t.branch.mode = m; t.branch.single_mode_select = s; t.store = st; t.load = ld;
    return t;
  endfunction

  task automatic add(input logic vl, input logic [3:0] i_t, g_t, a_t, b_t, m, input logic [1:0] j,
                     input dift_opclass_t o, input dift_tccr_t c, input logic er, input dift_trap_t et);
    vec_t x;
    x.valid = vl; x.it = i_t; x.tgt = g_t; x.ta = a_t; x.tb = b_t; x.mask = m; x.jmp = j;
    x.opc = o; x.tccr = c; x.exp_req = er; x.exp_type = et;
    v.push_back(x);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    valid = 0; it = 0; tgt = 0; ta = 0; tb = 0; mask = 0; jmp = BRANCH_NONE;
    opc = DIFT_OPCLASS_OTHER; tccr = '0; ack = 0; clr = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    add(1, 4'h2, 0, 0, 0, 4'hF, BRANCH_NONE, DIFT_OPCLASS_OTHER, mk(1,0,DIFT_BR_OFF,DIFT_SEL_OP_A,0,0), 1, DIFT_TRAP_TYPE_EXEC);
    add(1, 4'h2, 0, 0, 0, 4'h1, BRANCH_NONE, DIFT_OPCLASS_OTHER, mk(1,0,DIFT_BR_OFF,DIFT_SEL_OP_A,0,0), 0, DIFT_TRAP_TYPE_NONE);
    add(1, 4'h2, 0, 0, 0, 4'h3, BRANCH_NONE, DIFT_OPCLASS_OTHER, mk(1,0,DIFT_BR_OFF,DIFT_SEL_OP_A,0,0), 1, DIFT_TRAP_TYPE_EXEC);
    add(0, 4'h2, 0, 0, 0, 4'hF, BRANCH_NONE, DIFT_OPCLASS_OTHER, mk(1,0,DIFT_BR_OFF,DIFT_SEL_OP_A,0,0), 0, DIFT_TRAP_TYPE_NONE);
    add(1, 0, 4'h1, 4'h1, 0, 4'hF, BRANCH_JALR, DIFT_OPCLASS_STORE, mk(0,1,DIFT_BR_OFF,DIFT_SEL_OP_A,1,0), 1, DIFT_TRAP_TYPE_JALR);
    add(1, 0, 0, 4'h8, 0, 4'hF, BRANCH_NONE, DIFT_OPCLASS_STORE, mk(0,0,DIFT_BR_OFF,DIFT_SEL_OP_A,1,0), 1, DIFT_TRAP_TYPE_STOR);
    add(1, 0, 0, 4'h4, 0, 4'hF, BRANCH_NONE, DIFT_OPCLASS_LOAD, mk(0,0,DIFT_BR_OFF,DIFT_SEL_OP_A,0,1), 1, DIFT_TRAP_TYPE_LOAD);
    add(1, 0, 4'h1, 0, 0, 4'hF, BRANCH_COND, DIFT_OPCLASS_OTHER, mk(0,1,DIFT_BR_OFF,DIFT_SEL_OP_A,0,0), 0, DIFT_TRAP_TYPE_NONE);
    add(1, 0, 0, 4'h1, 4'h0, 4'hF, BRANCH_COND, DIFT_OPCLASS_OTHER, mk(0,0,DIFT_BR_SINGL,DIFT_SEL_OP_B,0,0), 0, DIFT_TRAP_TYPE_NONE);
    add(1, 0, 0, 4'h0, 4'h1, 4'hF, BRANCH_COND, DIFT_OPCLASS_OTHER, mk(0,0,DIFT_BR_SINGL,DIFT_SEL_OP_B,0,0), 1, DIFT_TRAP_TYPE_BRAN);
    add(1, 0, 0, 4'h1, 4'h0, 4'hF, BRANCH_COND, DIFT_OPCLASS_OTHER, mk(0,0,DIFT_BR_AND,DIFT_SEL_OP_A,0,0), 0, DIFT_TRAP_TYPE_NONE);
    add(1, 0, 0, 4'h1, 4'h2, 4'hF, BRANCH_COND, DIFT_OPCLASS_OTHER, mk(0,0,DIFT_BR_AND,DIFT_SEL_OP_A,0,0), 1, DIFT_TRAP_TYPE_BRAN);
    add(1, 0, 0, 4'h0, 4'h2, 4'hF, BRANCH_COND, DIFT_OPCLASS_OTHER, mk(0,0,DIFT_BR_OR,DIFT_SEL_OP_A,0,0), 1, DIFT_TRAP_TYPE_BRAN);
    add(1, 4'h1, 0, 4'h1, 0, 4'hF, BRANCH_NONE, DIFT_OPCLASS_LOAD, mk(1,0,DIFT_BR_OFF,DIFT_SEL_OP_A,0,1), 1, DIFT_TRAP_TYPE_EXEC);
    add(1, 0, 0, 4'h1, 4'h0, 4'hF, BRANCH_COND, DIFT_OPCLASS_OTHER, mk(0,0,DIFT_BR_SINGL,DIFT_SEL_OP_A,0,0), 1, DIFT_TRAP_TYPE_BRAN);
    add(1, 0, 0, 4'h1, 4'h1, 4'hF, BRANCH_COND, DIFT_OPCLASS_OTHER, mk(0,0,DIFT_BR_OFF,DIFT_SEL_OP_A,0,0), 0, DIFT_TRAP_TYPE_NONE);
    add(1, 0, 0, 4'h1, 0, 4'hF, BRANCH_NONE, DIFT_OPCLASS_STORE, mk(0,0,DIFT_BR_OFF,DIFT_SEL_OP_A,0,1), 0, DIFT_TRAP_TYPE_NONE);
    add(1, 0, 0, 4'h1, 0, 4'h2, BRANCH_NONE, DIFT_OPCLASS_LOAD, mk(0,0,DIFT_BR_OFF,DIFT_SEL_OP_A,0,1), 0, DIFT_TRAP_TYPE_NONE);

    do_reset();
    chk("reset_req", 32'(req), 0);
    chk("reset_type", 32'(ttype), 32'(DIFT_TRAP_TYPE_NONE));
    chk("reset_pc", tpc, 0);
    chk("reset_cnt", 32'(cnt), 0);
    chk("reset_ovf", 32'(ovf), 0);

    foreach (v[k]) begin
      do_reset();
      valid = v[k].valid; it = v[k].it; tgt = v[k].tgt; ta = v[k].ta; tb = v[k].tb;
      mask = v[k].mask; jmp = v[k].jmp; opc = v[k].opc; tccr = v[k].tccr;
      pc = 32'h100 + 32'(k) * 4;
      step();
      chk($sformatf("v%0d_req", k), 32'(req), 32'(v[k].exp_req));
      chk($sformatf("v%0d_type", k), 32'(ttype), 32'(v[k].exp_type));
      chk($sformatf("v%0d_pc", k), tpc, v[k].exp_req ? 32'h100 + 32'(k) * 4 : 32'h0);
      chk($sformatf("v%0d_cnt", k), 32'(cnt), 32'(v[k].exp_req));
    end

    do_reset();
    valid = 1; it = 4'h2; mask = 4'hF; tccr = mk(1,0,DIFT_BR_OFF,DIFT_SEL_OP_A,0,0); pc = 32'h100;
    step();
    valid = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("held_req", 32'(req), 1);
      chk("held_pc", tpc, 32'h100);
    end
    ack = 1;
    step();
    ack = 0;
    chk("ack_req", 32'(req), 0);
    chk("ack_cnt", 32'(cnt), 1);

    do_reset();
    valid = 1; it = 4'h1; tgt = 4'h1; jmp = BRANCH_JALR; mask = 4'hF;
    tccr = mk(1,1,DIFT_BR_OFF,DIFT_SEL_OP_A,0,0); pc = 32'h200;
    step();
    chk("pend_req", 32'(req), 1);
    chk("pend_type", 32'(ttype), 32'(DIFT_TRAP_TYPE_EXEC));
    chk("pend_cnt1", 32'(cnt), 1);
    it = 4'h0; pc = 32'h204;
    step();
    chk("pend_type2", 32'(ttype), 32'(DIFT_TRAP_TYPE_EXEC));
    chk("pend_pc2", tpc, 32'h200);
    chk("pend_cnt2", 32'(cnt), 2);
    step();
    chk("pend_cnt3", 32'(cnt), 3);
    chk("pend_ovf3", 32'(ovf), 0);
    step();
    chk("sat_cnt", 32'(cnt), 3);
    chk("sat_ovf", 32'(ovf), 1);
    chk("sat_pc", tpc, 32'h200);
    ack = 1;
    step();
    ack = 0;
    chk("hold1_req", 32'(req), 0);
    chk("hold1_type", 32'(ttype), 32'(DIFT_TRAP_TYPE_NONE));
    chk("hold1_pc", tpc, 0);
    step();
    chk("hold2_req", 32'(req), 0);
    step();
    chk("hold_exit_req", 32'(req), 0);
    step();
    chk("retrap_req", 32'(req), 1);
    chk("retrap_type", 32'(ttype), 32'(DIFT_TRAP_TYPE_JALR));
    chk("retrap_pc", tpc, 32'h204);
    clr = 1;
    step();
    clr = 0;
    chk("clr_cnt", 32'(cnt), 0);
    chk("clr_ovf", 32'(ovf), 0);
    chk("clr_req_kept", 32'(req), 1);
    valid = 0;
    step();
    #1 rst_n = 0;
    #1;
    chk("async_rst_req", 32'(req), 0);
    chk("async_rst_type", 32'(ttype), 32'(DIFT_TRAP_TYPE_NONE));
    chk("async_rst_pc", tpc, 0);
    @(negedge clk);
    rst_n = 1;
    step();
    chk("after_rst_req", 32'(req), 0);

    do_reset();
    ack = 1; valid = 1; ta = 4'h1; opc = DIFT_OPCLASS_LOAD; mask = 4'hF;
    tccr = mk(0,0,DIFT_BR_OFF,DIFT_SEL_OP_A,0,1); pc = 32'h300;
    step();
    chk("ack_idle_req", 32'(req), 1);
    chk("ack_idle_type", 32'(ttype), 32'(DIFT_TRAP_TYPE_LOAD));
    idle_inputs();
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule
